// File: rtl/port_b_pkg.sv
// Shared types and constants for the port-B read path: requester ownership,
// arbiter states, and the return tag that travels alongside each issued read.
package port_b_pkg;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_AUX  = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } arb_state_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   err;
    } tag_t;

    // Unified address map boundaries, also used by the memory stage range decode.
    localparam int IMG_ROM_WORDS = 90000;
    localparam int RAM_BASE      = 90000;

endpackage

// File: rtl/port_b_read_arbiter_if.sv
// Requester, memory-port and flush handshake signals of the port-B read arbiter.
// slave is the arbiter's view; master is the requesters/memory side.
interface port_b_read_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic              aux_req;
    logic [ADDR_W-1:0] aux_addr;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic              aux_err;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_address_b;
    logic [DATA_W-1:0] mem_read_data_b;
    logic              flush;
    logic              flush_done;

    modport slave (
        input  disp_req, disp_addr, aux_req, aux_addr, mem_read_data_b, flush,
        output disp_gnt, disp_rvalid, aux_gnt, aux_rvalid, aux_err, rdata,
               mem_address_b, flush_done
    );

    modport master (
        output disp_req, disp_addr, aux_req, aux_addr, mem_read_data_b, flush,
        input  disp_gnt, disp_rvalid, aux_gnt, aux_rvalid, aux_err, rdata,
               mem_address_b, flush_done
    );
endinterface

// File: rtl/read_tag_pipe.sv
// Fixed-depth shift register carrying {valid, owner, err} for each issued read,
// so the tag emerges exactly when the memory returns the matching data.
module read_tag_pipe
    import port_b_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/port_b_read_arbiter.sv
// Shares memory port B between display scanout and an aux reader: fixed display
// priority with an aux starvation guard, tagged return routing and flush/halt.
module port_b_read_arbiter
    import port_b_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 24,
    parameter int READ_LATENCY = 2,
    parameter int MAX_STARVE   = 4,
    parameter int ADDR_LIMIT   = 131071
) (
    input logic                  clk,
    input logic                  reset,
    port_b_read_arbiter_if.slave bus
);

    localparam int SW  = $clog2(MAX_STARVE + 1);
    localparam int IW  = $clog2(READ_LATENCY + 1);
    localparam int AW1 = ADDR_W + 1;
    localparam logic [SW-1:0]  STARVE_MAX = SW'(MAX_STARVE);
    localparam logic [AW1-1:0] LIMIT_EXT  = AW1'(ADDR_LIMIT);

    arb_state_t    state;
    logic          flush_done_q;
    logic [SW-1:0] starve_cnt;
    logic [IW-1:0] in_flight;
    logic [IW-1:0] in_flight_next;
    logic          grant_en;
    logic          disp_win;
    logic          aux_win;
    logic          aux_oob;
    logic          ret_any;
    tag_t          new_tag;
    tag_t          out_tag;

    // Grants are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        grant_en = reset && (state == RUN) && !bus.flush;
        aux_win  = grant_en && bus.aux_req &&
                   (!bus.disp_req || (starve_cnt == STARVE_MAX));
        disp_win = grant_en && bus.disp_req && !aux_win;
        aux_oob  = {1'b0, bus.aux_addr} > LIMIT_EXT;

        bus.mem_address_b = '0;
        if (disp_win) begin
            bus.mem_address_b = bus.disp_addr;
        end else if (aux_win && !aux_oob) begin
            bus.mem_address_b = bus.aux_addr;
        end

        new_tag.valid = disp_win || aux_win;
        new_tag.owner = aux_win ? OWN_AUX : OWN_DISP;
        new_tag.err   = aux_win && aux_oob;
    end

    read_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tags (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (new_tag),
        .tag_out (out_tag)
    );

    assign ret_any         = out_tag.valid;
    assign bus.disp_gnt    = disp_win;
    assign bus.aux_gnt     = aux_win;
    assign bus.disp_rvalid = out_tag.valid && (out_tag.owner == OWN_DISP);
    assign bus.aux_rvalid  = out_tag.valid && (out_tag.owner == OWN_AUX);
    assign bus.aux_err     = bus.aux_rvalid && out_tag.err;
    assign bus.rdata       = (ret_any && !out_tag.err) ? bus.mem_read_data_b : DATA_W'(0);
    assign bus.flush_done  = flush_done_q;

    always_comb begin
        case ({new_tag.valid, ret_any})
            2'b10:   in_flight_next = in_flight + IW'(1);
            2'b01:   in_flight_next = in_flight - IW'(1);
            default: in_flight_next = in_flight;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            in_flight  <= '0;
        end else begin
            in_flight <= in_flight_next;
            if (bus.aux_req && !aux_win) begin
                if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Leaving DRAIN looks at the post-retire count so HALTED follows the last rvalid directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            flush_done_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (in_flight_next == '0) begin
                        if (bus.flush) begin
                            state        <= HALTED;
                            flush_done_q <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                HALTED: begin
                    if (!bus.flush) begin
                        state        <= RUN;
                        flush_done_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= RUN;
                    flush_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/port_b_read_arbiter.md
Name: port_b_read_arbiter

Overview:
- Shares the memory stage's second read port (address_b / read_data_b) between two requesters: the display scanout (disp) and an auxiliary reader (aux, e.g. debug/UART dump).
- Fixed display priority, with a starvation guard that guarantees aux progress.
- Tags every issued read through the fixed memory read latency and routes returned data to the owner.
- Provides a flush/halt handshake so the port can be quiesced before the image is reloaded.

Parameters:
- ADDR_W, 17, address width of port B.
- DATA_W, 24, pixel/word width.
- READ_LATENCY, 2, cycles from address presented to data valid; covers the memory input and output registers.
- MAX_STARVE, 4, consecutive cycles aux may wait while requesting before it is forced a grant.
- ADDR_LIMIT, 131071, highest legal unified address (image ROM 0..89999, RAM 90000..ADDR_LIMIT).

Ports:
- clk  in  1  system clock; drives the memory stage's clk_b.
- reset  in  1  asynchronous, active-low reset.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display unified address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rvalid  out  1  rdata belongs to display this cycle.
- aux_req  in  1  aux read request.
- aux_addr  in  ADDR_W  aux unified address.
- aux_gnt  out  1  aux request accepted this cycle.
- aux_rvalid  out  1  rdata belongs to aux this cycle.
- aux_err  out  1  returned aux read was out of range.
- rdata  out  DATA_W  returned read data, shared by both requesters.
- mem_address_b  out  ADDR_W  to memory_stage address_b.
- mem_read_data_b  in  DATA_W  from memory_stage read_data_b.
- flush  in  1  request to quiesce the port.
- flush_done  out  1  no grants and nothing in flight.

Behaviour:

Reset:
- All outputs 0, FSM = RUN, starve counter 0, tag pipeline empty.

Handshake:
- A request is accepted in cycle T when its gnt=1 in T.
- Each requester holds req/addr until its gnt is seen.
- At most one grant per cycle.
- gnt is combinational from req, FSM state and the starve counter.

Arbitration (RUN only):
- Default winner is disp.
- aux wins if disp_req=0, or if starve_cnt==MAX_STARVE.
- starve_cnt increments each cycle aux_req=1 && aux_gnt=0, saturating at MAX_STARVE.
- starve_cnt clears on aux_gnt or when aux_req=0.

Port drive:
- mem_address_b = granted address in T; 0 when there is no grant.
- An aux address > ADDR_LIMIT is still granted, but mem_address_b is driven 0 and its tag is marked err.

Return path:
- A tag pipeline of depth READ_LATENCY, with fields {valid, owner, err}, shifts every cycle.
- At T+READ_LATENCY the pipeline output sets disp_rvalid or aux_rvalid for exactly one cycle.
- rdata = mem_read_data_b, or 0 when err (then aux_err=1 with aux_rvalid).
- rdata = 0 when no rvalid.
- Responses return strictly in grant order; back-to-back grants give back-to-back rvalids.

In-flight counter:
- Range 0..READ_LATENCY.
- +1 on a grant, −1 on an rvalid; both in the same cycle leaves it unchanged.

FSM:
- RUN: grants enabled. flush=1 → DRAIN; no grant is issued in the cycle flush is first seen.
- DRAIN: no grants, tags continue to retire. in-flight==0 → HALTED.
- HALTED: flush_done=1, no grants. flush=0 → RUN (grants resume the next cycle).
- flush dropped during DRAIN → RUN once in-flight==0, with no flush_done pulse.

Reset mid-operation:
- In-flight tags are discarded; no rvalid is produced for pre-reset grants.

Decomposition:
- Shared package port_b_pkg:
  - owner_t enum {OWN_DISP, OWN_AUX}.
  - arb_state_t enum {RUN, DRAIN, HALTED}.
  - Constants IMG_ROM_WORDS=90000 and RAM_BASE=90000, reused by memory_stage range decode.
- Sub-module read_tag_pipe: a parameterised READ_LATENCY-deep shift register of {valid, owner, err}.
- Arbiter, starve counter and FSM stay in the top module.

Test Plan:
- disp_req=1 every cycle, addresses 0,1,2…, mem model returns addr+0x100 → disp_rvalid with 0x000100,0x000101… exactly 2 cycles after each grant, no gaps.
- disp_req=1 constant, aux_req=1 at aux_addr=90005 → aux_gnt on the 5th waiting cycle (starve_cnt reaches 4), one disp grant skipped, aux_rvalid 2 cycles later with RAM data, then disp resumes.
- aux_addr=131071 then a request with ADDR_LIMIT set to 120000 → the first returns RAM data; the second gives aux_rvalid=1, aux_err=1, rdata=0, and mem_address_b=0 in its grant cycle.
- Alternate disp/aux grants, assert flush one cycle after a grant → no further gnt, both in-flight rvalids delivered, flush_done=1 on the cycle after the last rvalid; drop flush → grant the next cycle.
- Assert reset (0) one cycle after a grant → all outputs 0 immediately; no rvalid appears in the following cycles after reset releases.
